cd_spi_csr_bridge: RTL and testbench

- SPI slave (mode 0) that acts as the initiator on the 4-bit-address / 32-bit-data CSR bus of the CDBUS controller.
- Converts host SPI transactions into single-cycle csr_read / csr_write strobes.
- Drives chip_select so the CSR target can snapshot interrupt flags and reset its data pointers per transaction.
- SPI pins are oversampled in the clk domain; no SCK clock domain exists.

---
 rtl/cd_spi_csr_bridge.sv | 123 ++++++++++++
 tb/tb_cd_spi_csr_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cd_spi_csr_bridge.sv
// rtl/cd_spi_csr_bridge.sv - SPI mode-0 slave that drives single-cycle CSR read/write strobes
module cd_spi_csr_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_nss,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        chip_select,
    output logic [3:0]  csr_address,
    output logic        csr_read,
    input  logic [31:0] csr_readdata,
    output logic        csr_write,
    output logic [31:0] csr_writedata
);
    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_pipe, nss_pipe, mosi_pipe;
    logic        sck_d, nss_d;
    logic        sck_s, nss_s, mosi_s;
    logic        sck_rise, sck_fall, nss_rise, nss_fall;
    logic [4:0]  bit_cnt;
    logic [31:0] shift_reg;
    logic [7:0]  cmd_byte;
    logic        write_pend;
    logic        cmd_done, word_done, read_req;

    assign sck_s    = sck_pipe[SYNC_STAGES-1];
    assign nss_s    = nss_pipe[SYNC_STAGES-1];
    assign mosi_s   = mosi_pipe[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign nss_rise = nss_s & ~nss_d;
    assign nss_fall = ~nss_s & nss_d;
    assign cmd_byte = {shift_reg[6:0], mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_pipe  <= '0;
            nss_pipe  <= '1;
            mosi_pipe <= '0;
            sck_d     <= 1'b0;
            nss_d     <= 1'b1;
        end else begin
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_sck};
            nss_pipe  <= {nss_pipe[SYNC_STAGES-2:0], spi_nss};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
            nss_d     <= nss_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // nss rising wins over any sck edge seen in the same cycle
    always_comb begin
        state_next = state;
        if (nss_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (nss_fall) state_next = CMD;
                CMD:  if (sck_rise && bit_cnt == 5'd7) state_next = cmd_byte[7] ? WR : RD;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        cmd_done  = 1'b0;
        word_done = 1'b0;
        read_req  = 1'b0;
        if (!nss_rise && sck_rise) begin
            cmd_done  = (state == CMD) && (bit_cnt == 5'd7);
            word_done = (state == WR) && (bit_cnt == 5'd31);
            read_req  = (cmd_done && !cmd_byte[7]) || ((state == RD) && (bit_cnt == 5'd31));
        end
    end

    // Target read data is sampled while csr_read is high, i.e. once csr_address is already valid
    always_ff @(posedge clk) begin
        if (reset) begin
            chip_select   <= 1'b0;
            spi_miso_oe   <= 1'b0;
            csr_address   <= 4'd0;
            csr_read      <= 1'b0;
            csr_write     <= 1'b0;
            csr_writedata <= 32'd0;
            write_pend    <= 1'b0;
            bit_cnt       <= 5'd0;
            shift_reg     <= 32'd0;
        end else begin
            chip_select <= ~nss_s;
            spi_miso_oe <= ~nss_s;
            csr_read    <= read_req;
            write_pend  <= word_done;
            csr_write   <= write_pend & ~nss_s;
            if (cmd_done)  csr_address   <= cmd_byte[3:0];
            if (word_done) csr_writedata <= {shift_reg[30:0], mosi_s};

            if (state == IDLE || nss_rise || cmd_done) bit_cnt <= 5'd0;
            else if (sck_rise)                         bit_cnt <= bit_cnt + 5'd1;

            if (state == RD && csr_read)
                shift_reg <= csr_readdata;
            else if (sck_rise && (state == CMD || state == WR))
                shift_reg <= {shift_reg[30:0], mosi_s};
            else if (state == RD && sck_fall && bit_cnt != 5'd0)
                shift_reg <= {shift_reg[30:0], 1'b0};
        end
    end

    assign spi_miso = (state == RD) & shift_reg[31];

endmodule

// File: tb/tb_cd_spi_csr_bridge.sv
// tb/tb_cd_spi_csr_bridge.sv - table-driven SPI frame bench with CSR strobe scoreboard
module tb_cd_spi_csr_bridge;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_nss = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, chip_select, csr_read, csr_write;
    logic [3:0]  csr_address;
    logic [31:0] csr_readdata, csr_writedata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         wr;
        logic [3:0] addr;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [7:0]       cmd;
        int               nwords;
        int               abort_bits;
        int               hp;
        logic [5:0][31:0] data;
    } vec_t;
    vec_t vecs[$];

    logic [5:0][31:0] tgt_mem = '0;
    int tgt_idx = 0;

    cd_spi_csr_bridge #(.SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_nss(spi_nss),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .chip_select(chip_select), .csr_address(csr_address), .csr_read(csr_read),
        .csr_readdata(csr_readdata), .csr_write(csr_write), .csr_writedata(csr_writedata)
    );

    always #5 clk = ~clk;

    // Target model: returns successive words per read, rewinds while deselected
    assign csr_readdata = tgt_mem[(tgt_idx > 5) ? 5 : tgt_idx];
    always @(posedge clk) begin
        if (!chip_select) tgt_idx <= 0;
        else if (csr_read) tgt_idx <= tgt_idx + 1;
    end

    always @(negedge clk) begin
        if (!reset && (csr_read || csr_write)) begin
            ev_t e;
            checks++;
            if (csr_read && csr_write) begin
                errors++;
                $display("FAIL strobe_overlap rd=%0b wr=%0b required one only", csr_read, csr_write);
            end
            checks++;
            if (!chip_select) begin
                errors++;
                $display("FAIL strobe_without_cs chip_select=%0b required 1", chip_select);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe rd=%0b wr=%0b addr=%h data=%h", csr_read, csr_write, csr_address, csr_writedata);
            end else begin
                e = exp_q.pop_front();
                if (e.wr !== csr_write || e.addr !== csr_address || (e.wr && e.data !== csr_writedata)) begin
                    errors++;
                    $display("FAIL strobe_match got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h",
                             csr_write, csr_address, csr_writedata, e.wr, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sck_cycle(input logic mosi_bit, input int hp, output logic miso_bit);
        spi_mosi = mosi_bit;
        clks(hp);
        spi_sck  = 1'b1;
        miso_bit = spi_miso;
        clks(hp);
        spi_sck  = 1'b0;
    endtask

    task automatic add_vec(input logic [7:0] cmd, input int nw, input int ab, input int hp,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] d3, input logic [31:0] d4, input logic [31:0] d5);
        vec_t v;
        v.cmd = cmd; v.nwords = nw; v.abort_bits = ab; v.hp = hp;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
        v.data[3] = d3; v.data[4] = d4; v.data[5] = d5;
        vecs.push_back(v);
    endtask

    task automatic push_ev(input bit wr, input logic [3:0] addr, input logic [31:0] data);
        ev_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input vec_t v, input int id);
        logic [31:0] got;
        logic        b;
        int          nbits;
        tgt_mem = v.data;
        nbits = (v.abort_bits >= 0) ? v.abort_bits : 32;
        if (v.cmd[7]) begin
            if (v.abort_bits < 0)
                for (int k = 0; k < v.nwords; k++) push_ev(1'b1, v.cmd[3:0], v.data[k]);
        end else begin
            for (int k = 0; k <= v.nwords; k++) push_ev(1'b0, v.cmd[3:0], 32'd0);
        end
        spi_nss = 1'b0;
        clks(v.hp);
        for (int i = 7; i >= 0; i--) sck_cycle(v.cmd[i], v.hp, b);
        for (int w = 0; w < v.nwords; w++) begin
            got = 32'd0;
            for (int i = 0; i < nbits; i++) begin
                sck_cycle(v.cmd[7] ? v.data[w][31-i] : 1'b0, v.hp, b);
                got = {got[30:0], b};
            end
            if (!v.cmd[7] && nbits == 32) chk($sformatf("miso_word v%0d w%0d", id, w), got, v.data[w]);
        end
        clks(v.hp);
        spi_nss = 1'b1;
        clks(S + 2);
        chk($sformatf("cs_drop v%0d", id), {31'd0, chip_select}, 32'd0);
        clks(4);
        chk($sformatf("sb_empty v%0d", id), exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic b;
        add_vec(8'h87, 1, -1, 6, 32'h12345678, 0, 0, 0, 0, 0);
        add_vec(8'h8B, 3, -1, 6, 32'hA0000001, 32'hA0000002, 32'hA0000003, 0, 0, 0);
        add_vec(8'h00, 1, -1, 6, 32'h0000000F, 32'h55AA55AA, 0, 0, 0, 0);
        add_vec(8'h86, 1, 20, 6, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        add_vec(8'h86, 1, -1, 6, 32'h000000AA, 0, 0, 0, 0, 0);
        add_vec(8'h0B, 5, -1, S + 3, 32'h8000_0001, 32'h1234_ABCD, 32'hFFFF_0000,
                32'h0F0F_F0F0, 32'h7FFF_FFFE, 32'hC3C3_3C3C);
        add_vec(8'h03, 0, -1, 6, 32'h11111111, 0, 0, 0, 0, 0);
        add_vec(8'h85, 0, -1, 6, 32'h22222222, 0, 0, 0, 0, 0);

        clks(4);
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("rst_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("rst_cs", {31'd0, chip_select}, 32'd0);
        chk("rst_addr", {28'd0, csr_address}, 32'd0);
        chk("rst_rd", {31'd0, csr_read}, 32'd0);
        chk("rst_wr", {31'd0, csr_write}, 32'd0);
        chk("rst_wdata", csr_writedata, 32'd0);
        reset = 1'b0;
        clks(4);

        for (int i = 0; i < vecs.size(); i++) begin
            run_frame(vecs[i], i);
            if (i == 3) chk("abort_wdata_kept", csr_writedata, 32'hA0000003);
            clks(8);
        end

        // Reset in the middle of a read word
        tgt_mem[0] = 32'hF00DCAFE;
        push_ev(1'b0, 4'h5, 32'd0);
        spi_nss = 1'b0;
        clks(6);
        for (int i = 7; i >= 0; i--) sck_cycle(i < 3 ? (4'h5 >> i) & 1'b1 : 1'b0, 6, b);
        for (int i = 0; i < 10; i++) sck_cycle(1'b0, 6, b);
        chk("pre_rst_oe", {31'd0, spi_miso_oe}, 32'd1);
        reset = 1'b1;
        clks(1);
        chk("mid_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("mid_rst_cs", {31'd0, chip_select}, 32'd0);
        chk("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("mid_rst_strobes", {30'd0, csr_read, csr_write}, 32'd0);
        reset = 1'b0;
        clks(3);
        spi_nss = 1'b1;
        clks(10);
        chk("rst_sb_empty", exp_q.size(), 32'd0);
        run_frame(vecs[2], 100);
        run_frame(vecs[0], 101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
